// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if
//  Groups the job handshake, operand flow control and DSP48A1 control/status signals
//  of the MAC sequencer.
//  master : job scheduler side (drives job_*, op_valid, abort; observes everything else)
//  slave  : sequencer side (drives ready/CE/OPMODE/RSTP/result/status signals)
interface dsp_mac_sequencer_if #(
   parameter int LENW = 8
);
   logic            job_valid;
   logic            job_ready;
   logic [LENW-1:0] job_len;
   logic            job_preadd;
   logic            job_sub;
   logic            job_accum;
   logic            op_valid;
   logic            op_ready;
   logic            abort;
   logic            CEA;
   logic            CEB;
   logic            CED;
   logic            CEOPMODE;
   logic            CEM;
   logic            CEP;
   logic            RSTP;
   logic [7:0]      OPMODE;
   logic            res_valid;
   logic            res_last;
   logic            busy;
   logic            done;

   modport master (
      output job_valid, job_len, job_preadd, job_sub, job_accum, op_valid, abort,
      input  job_ready, op_ready, CEA, CEB, CED, CEOPMODE, CEM, CEP, RSTP, OPMODE,
             res_valid, res_last, busy, done
   );

   modport slave (
      input  job_valid, job_len, job_preadd, job_sub, job_accum, op_valid, abort,
      output job_ready, op_ready, CEA, CEB, CED, CEOPMODE, CEM, CEP, RSTP, OPMODE,
             res_valid, res_last, busy, done
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//  Job-level controller for one DSP48A1 slice. Accepts a job, clears P, streams
//  operand pairs under op_valid/op_ready, and tracks each product through the slice
//  pipeline so P is enabled only for real products and results are flagged.
//  Ports:
//   clk   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   bus   : dsp_mac_sequencer_if.slave (job handshake, operand flow control,
//           slice CE/OPMODE/RSTP, result and status flags)
module dsp_mac_sequencer #(
   parameter int LAT  = 4,
   parameter int LENW = 8
) (
   input logic                  clk,
   input logic                  RST_N,
   dsp_mac_sequencer_if.slave   bus
);
   // vld_pipe[0] is loaded by fire; vld_pipe[STAGES] is the P load enable.
   localparam int STAGES = LAT - 2;

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [LENW-1:0] len_q;
   logic            accum_q;
   logic [7:0]      opmode_q;
   logic [LENW-1:0] count;
   logic [STAGES:0] vld_pipe;
   logic [STAGES:0] last_pipe;
   logic            res_valid_q, res_last_q;

   logic abort_act, fire, last_fire, accept, cep;
   logic job_ready_c, rstp_c, ceopmode_c, done_c;

   // abort is meaningless in IDLE; elsewhere it overrides every other action.
   assign abort_act = bus.abort && (state != IDLE);
   assign fire      = (state == STREAM) && bus.op_valid && !abort_act;
   assign last_fire = fire && (count == LENW'(len_q - 1'b1));
   assign accept    = (state == IDLE) && bus.job_valid;
   assign cep       = vld_pipe[STAGES];

   always_comb begin
      state_nxt   = state;
      job_ready_c = 1'b0;
      rstp_c      = 1'b0;
      ceopmode_c  = 1'b0;
      done_c      = 1'b0;
      case (state)
         IDLE: begin
            job_ready_c = 1'b1;
            if (bus.job_valid) state_nxt = (bus.job_len == '0) ? DONE : CLEAR;
         end
         CLEAR: begin
            rstp_c     = 1'b1;
            ceopmode_c = 1'b1;
            state_nxt  = STREAM;
         end
         STREAM: if (last_fire) state_nxt = DRAIN;
         DRAIN:  if (vld_pipe == '0) state_nxt = DONE;
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort_act) begin
         state_nxt = IDLE;
         rstp_c    = 1'b1;
         done_c    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         len_q       <= '0;
         accum_q     <= 1'b0;
         opmode_q    <= '0;
         count       <= '0;
         vld_pipe    <= '0;
         last_pipe   <= '0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            len_q   <= bus.job_len;
            accum_q <= bus.job_accum;
            count   <= '0;
            // OPMODE only moves when a streaming job starts; it is stable through CLEAR
            // (where CEOPMODE loads it into the slice) and the whole job.
            if (bus.job_len != '0)
               opmode_q <= {1'b0, bus.job_sub, 1'b0, bus.job_preadd,
                            bus.job_accum ? 2'b10 : 2'b00, 2'b01};
         end
         if (abort_act) begin
            count       <= '0;
            vld_pipe    <= '0;
            last_pipe   <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
         end else begin
            // count stops at len-1 so it can never wrap.
            if (fire && !last_fire) count <= count + 1'b1;
            vld_pipe[0]  <= fire;
            last_pipe[0] <= last_fire;
            for (int i = 1; i <= STAGES; i++) begin
               vld_pipe[i]  <= vld_pipe[i-1];
               last_pipe[i] <= last_pipe[i-1];
            end
            // In accumulate mode only the final sum is a result.
            res_valid_q <= cep && (!accum_q || last_pipe[STAGES]);
            res_last_q  <= cep && last_pipe[STAGES];
         end
      end
   end

   assign bus.job_ready = job_ready_c;
   assign bus.op_ready  = (state == STREAM) && !abort_act;
   assign bus.CEA       = fire;
   assign bus.CEB       = fire;
   assign bus.CED       = fire;
   assign bus.CEOPMODE  = ceopmode_c;
   assign bus.CEM       = (state != IDLE);
   assign bus.CEP       = cep;
   assign bus.RSTP      = rstp_c;
   assign bus.OPMODE    = opmode_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_last  = res_last_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_c;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer
//  Table of directed jobs with hand-computed expectations, plus hand-written abort and
//  asynchronous-reset sequences. A small P-register model follows the slice controls.
module tb_dsp_mac_sequencer;
   localparam int LAT  = 4;
   localparam int LENW = 8;

   logic clk = 1'b0;
   logic RST_N;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   dsp_mac_sequencer_if #(.LENW(LENW)) bus ();
   dsp_mac_sequencer #(.LAT(LAT), .LENW(LENW)) dut (.clk(clk), .RST_N(RST_N), .bus(bus));

   typedef struct {
      int         len;
      bit         preadd, sub, accum, tog;
      int         a, b, d;
      logic [7:0] opm;
      int         n_cep, n_res, first_res, done_t;
      longint     p;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [20:0] outs();
      return {bus.job_ready, bus.op_ready, bus.CEA, bus.CEB, bus.CED, bus.CEOPMODE, bus.CEM,
              bus.CEP, bus.RSTP, bus.OPMODE, bus.res_valid, bus.res_last, bus.busy, bus.done};
   endfunction

   // Slice multiplier input as selected by OPMODE: pre-adder in use -> D+B or D-B.
   function automatic longint prod(input logic [7:0] op, input vec_t v);
      longint m;
      m = op[4] ? (op[6] ? longint'(v.d - v.b) : longint'(v.d + v.b)) : longint'(v.b);
      return longint'(v.a) * m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one job from IDLE; t=0 is the accept cycle. Stops at done or after a budget.
   task automatic run_vec(input string nm, input vec_t v);
      int n_fire = 0, n_cep = 0, n_res = 0, n_last = 0, n_done = 0, n_ceopm = 0;
      int first_res = -1, done_t = -1, lat_err = 0, last_fire = -1, ovl = 0, t = 0, f;
      logic [7:0] opm_seen = '0;
      longint p_mdl = 0, p_last = 0, x;
      longint pq[$];
      int fq[$];
      bit fin = 0;
      bus.job_valid  = 1'b1;
      bus.job_len    = LENW'(v.len);
      bus.job_preadd = v.preadd;
      bus.job_sub    = v.sub;
      bus.job_accum  = v.accum;
      while (!fin && t < 400) begin
         bus.op_valid = v.tog ? (t % 2 == 0) : 1'b1;
         @(negedge clk);
         if (bus.CEOPMODE) begin n_ceopm++; opm_seen = bus.OPMODE; end
         if (bus.CEA) begin
            n_fire++; last_fire = t; fq.push_back(t); pq.push_back(prod(bus.OPMODE, v));
         end
         if (bus.CEP) n_cep++;
         if (bus.res_valid) begin
            n_res++;
            if (first_res < 0) first_res = t;
            if (!v.accum) begin
               if (fq.size() == 0) lat_err++;
               else begin f = fq.pop_front(); if (t - f != LAT) lat_err++; end
            end
         end
         if (bus.res_last) begin
            n_last++; p_last = p_mdl;
            if (t - last_fire != LAT) lat_err++;
         end
         if (bus.done) begin
            n_done++; done_t = t; fin = 1;
            if (bus.job_ready) ovl++;
         end
         if (bus.RSTP) p_mdl = 0;
         else if (bus.CEP) begin
            x = (pq.size() != 0) ? pq.pop_front() : 0;
            p_mdl = bus.OPMODE[3] ? p_mdl + x : x;
         end
         step();
         bus.job_valid = 1'b0;
         t++;
      end
      chk({nm, " finished"}, fin, 1);
      chk({nm, " ceopmode"}, n_ceopm, (v.len != 0) ? 1 : 0);
      if (v.len != 0) chk({nm, " opmode"}, opm_seen, v.opm);
      chk({nm, " fires"}, n_fire, v.len);
      chk({nm, " cep"}, n_cep, v.n_cep);
      chk({nm, " res_valid"}, n_res, v.n_res);
      chk({nm, " res_last"}, n_last, (v.len != 0) ? 1 : 0);
      chk({nm, " first_res"}, first_res, v.first_res);
      chk({nm, " done_t"}, done_t, v.done_t);
      chk({nm, " done_cnt"}, n_done, 1);
      chk({nm, " latency"}, lat_err, 0);
      chk({nm, " done_overlap"}, ovl, 0);
      if (v.n_res != 0) chk({nm, " P"}, p_last, v.p);
   endtask

   initial begin
      int n_fire, n_bad;
      //            len pa sb ac tg  a  b   d  opm     cep res first done  P
      vecs[0] = '{3, 0, 0, 1, 0, 3, 4,  0, 8'h09, 3, 1, 8,  9,  36};
      vecs[1] = '{4, 0, 0, 0, 1, 5, 6,  0, 8'h01, 4, 4, 6,  13, 30};
      vecs[2] = '{2, 1, 1, 1, 0, 2, 3, 10, 8'h59, 2, 1, 7,  8,  28};
      vecs[3] = '{0, 0, 0, 0, 0, 1, 1,  1, 8'h00, 0, 0, -1, 1,  0};
      vecs[4] = '{1, 1, 0, 0, 0, 4, 1,  2, 8'h11, 1, 1, 6,  7,  12};
      vecs[5] = '{5, 1, 0, 1, 1, 1, 2,  3, 8'h19, 5, 1, 14, 15, 25};

      RST_N = 1'b0;
      bus.job_valid = 0; bus.job_len = '0; bus.job_preadd = 0; bus.job_sub = 0;
      bus.job_accum = 0; bus.op_valid = 0; bus.abort = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", outs(), 21'h100000);
      @(negedge clk);
      RST_N = 1'b1;
      step();
      chk("idle outputs", outs(), 21'h100000);

      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Abort after two of five fires.
      bus.job_valid = 1; bus.job_len = 8'd5; bus.job_preadd = 0; bus.job_sub = 0;
      bus.job_accum = 1; bus.op_valid = 1;
      step();
      bus.job_valid = 0;
      n_fire = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.CEA) n_fire++;
         step();
      end
      chk("abort fires before", n_fire, 2);
      bus.abort = 1;
      @(negedge clk);
      chk("abort rstp", bus.RSTP, 1);
      chk("abort no fire", {bus.op_ready, bus.CEA}, 0);
      step();
      bus.abort = 0;
      @(negedge clk);
      chk("abort idle", {bus.job_ready, bus.busy}, 2'b10);
      n_bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.res_valid || bus.done || bus.CEP) n_bad++;
      end
      step();
      chk("abort quiet", n_bad, 0);
      run_vec("post_abort", vecs[0]);

      // Asynchronous reset while draining.
      bus.job_valid = 1; bus.job_len = 8'd3; bus.job_accum = 1; bus.op_valid = 1;
      step();
      bus.job_valid = 0;
      repeat (4) step();
      @(negedge clk);
      chk("drain reached", {bus.busy, bus.op_ready, bus.CEP}, 3'b101);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async reset outputs", outs(), 21'h100000);
      @(negedge clk);
      RST_N = 1'b1;
      step();
      run_vec("post_reset", vecs[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
